lab3_block_copier: RTL and testbench
====================================

Name: lab3_block_copier

Overview:
Bus initiator for the lab3 data-memory port. It drives ADDR/DATA/MW and samples Q to copy a block of LEN bytes from SRC to DST, one byte at a time in ascending address order. It is the other end of the data-memory interface: it sits beside the CPU and owns the bus only while GNT is high. Typical uses are relocating the BCD lookup table and streaming bytes to the output IO registers at 252..255.

Parameters:
HOLE_ADDR, 8'd248, unmapped address; a copy range that covers it is rejected.
PRE_ERR_HOLD, 1, reserved; ERR is sticky until the next START (no other value supported).

Ports:
CLK  input  1  system clock; all state changes on posedge.
RESET  input  1  asynchronous, active-low reset.
START  input  1  one-cycle request; sampled only in IDLE.
SRC  input  8  source base address; sampled with START.
DST  input  8  destination base address; sampled with START.
LEN  input  8  byte count (0..255); sampled with START.
GNT  input  1  bus grant from the arbiter; when low the block drives no access.
Q  input  8  memory read data (combinational from ADDR).
BUSY  output  1  high in RD and WR states.
REQ  output  1  bus request; equals BUSY.
DONE  output  1  one-cycle pulse on completion.
ERR  output  1  sticky range-error flag.
ADDR  output  8  memory address.
DATA  output  8  memory write data.
MW  output  1  memory write enable.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to IDLE.
  - BUSY, REQ, DONE, ERR, MW are 0; ADDR and DATA are 0.
  - Index counter and hold register are 0.
  - Reset mid-copy abandons the copy; bytes already written stay written.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - ADDR, DATA and MW are 0.
  - On START, latch SRC, DST, LEN, clear the index i, and clear ERR.
  - Range check, in 8-bit modular arithmetic: the range is bad if (HOLE_ADDR - SRC) mod 256 < LEN, or (HOLE_ADDR - DST) mod 256 < LEN.
  - If bad: set ERR, go to FIN, make no bus access.
  - Else if LEN==0: go to FIN.
  - Else: go to RD.
- RD:
  - ADDR = SRC+i (mod 256), MW = 0.
  - If GNT, capture Q into the hold register and go to WR; else stay.
- WR:
  - ADDR = DST+i (mod 256), DATA = hold, MW = GNT.
  - If GNT, then i = i+1; if i+1 == LEN go to FIN, else go to RD.
  - If not GNT, stay in WR with MW = 0.
- FIN:
  - DONE = 1 for exactly one cycle, then go to IDLE.
  - ERR remains set until the next accepted START.
- START outside IDLE is ignored; SRC, DST and LEN are don't-care outside the START cycle.
- Latency with GNT held high and LEN=N>0:
  - START is sampled at edge 0.
  - BUSY is high for 2N cycles.
  - DONE is high in cycle 2N+1.
  - The zero-length and error paths give DONE in cycle 1.
- Addresses wrap past 255 to 0; a range that wraps is legal if it does not cover HOLE_ADDR.
- Copy direction is forward only. Overlap with DST > SRC replicates bytes; this is documented, not flagged.
- IO addresses are legal. Reads from 249..251 return the IOA..IOC inputs; writes to 252..255 load IOD..IOG.
- GNT deassert is honoured every cycle. MW is never high while GNT is low, and no byte is skipped or duplicated.

Decomposition:
- Package lab3_bus_pkg holds:
  - the state encoding (IDLE, RD, WR, FIN);
  - HOLE_ADDR = 248;
  - IO address constants: IOA = 249 through IOG = 255.
- One natural sub-module, lab3_range_check: combinational, inputs base[7:0] and len[7:0], output covers_hole. It is instantiated twice (for SRC and DST).

Test Plan:
- Preload mem[0..3] = 00,00,08,00, GNT=1. START with SRC=0, DST=100, LEN=4 → MW pulses at ADDR 100..103, mem[100..103] equals the source bytes, DONE in cycle 9.
- START with LEN=0, SRC=10, DST=20 → no MW, BUSY stays 0, DONE in cycle 1, ERR=0.
- START with SRC=246, DST=0, LEN=4 (covers 248) → ERR=1, DONE in cycle 1, no MW, memory unchanged. A following good START clears ERR.
- SRC=0, DST=252, LEN=4 with mem[0..3] = 11,22,33,44 → IOD=11, IOE=22, IOF=33, IOG=44.
- LEN=2 with GNT low for 3 cycles during the first WR → MW stays 0 while GNT is low, both bytes are written exactly once, DONE in cycle 8.
- RESET low for one cycle during the second byte's RD of a LEN=4 copy → outputs zero immediately, only byte 0 is written, BUSY stays 0 afterwards.

Source files
------------

// File: rtl/lab3_bus_pkg.sv
// Shared definitions for the lab3 data-memory bus: copier state encoding,
// the unmapped hole and the IO register map.
package lab3_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [7:0] HOLE_ADDR = 8'd248;

  // IOA..IOC are read-only inputs, IOD..IOG are write-only output registers.
  localparam logic [7:0] IOA = 8'd249;
  localparam logic [7:0] IOB = 8'd250;
  localparam logic [7:0] IOC = 8'd251;
  localparam logic [7:0] IOD = 8'd252;
  localparam logic [7:0] IOE = 8'd253;
  localparam logic [7:0] IOF = 8'd254;
  localparam logic [7:0] IOG = 8'd255;

  function automatic logic [7:0] wrap_add(input logic [7:0] base, input logic [7:0] ofs);
    wrap_add = base + ofs;
  endfunction

endpackage

// File: rtl/lab3_block_copier_if.sv
// Data-memory bus seen by an initiator: request/grant plus the
// address/write-data/write-enable/read-data port.
interface lab3_block_copier_if;
  logic       REQ;
  logic       GNT;
  logic [7:0] ADDR;
  logic [7:0] DATA;
  logic       MW;
  logic [7:0] Q;

  modport master (output REQ, output ADDR, output DATA, output MW,
                  input  GNT, input  Q);
  modport slave  (input  REQ, input  ADDR, input  DATA, input  MW,
                  output GNT, output Q);
endinterface

// File: rtl/lab3_range_check.sv
// Flags a byte range [base, base+len) (mod 256) that includes the unmapped hole.
module lab3_range_check
  import lab3_bus_pkg::*;
#(
  parameter logic [7:0] HOLE = HOLE_ADDR
) (
  input  logic [7:0] base,
  input  logic [7:0] len,
  output logic       covers_hole
);

  logic [7:0] dist_s;

  // Distance from base forward to the hole; the range reaches it when len exceeds it.
  assign dist_s      = HOLE - base;
  assign covers_hole = (dist_s < len);

endmodule

// File: rtl/lab3_block_copier.sv
// Byte-at-a-time block copier acting as a data-memory bus initiator;
// copies LEN bytes from SRC to DST in ascending order while GNT is held.
module lab3_block_copier
  import lab3_bus_pkg::*;
#(
  parameter logic [7:0] HOLE_ADDR    = lab3_bus_pkg::HOLE_ADDR,
  parameter int         PRE_ERR_HOLD = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [7:0]          SRC,
  input  logic [7:0]          DST,
  input  logic [7:0]          LEN,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR,
  lab3_block_copier_if.master bus
);

  localparam logic HOLD_ERR = (PRE_ERR_HOLD == 1);

  state_t     state_r, state_nxt_s;
  logic [7:0] src_r, src_nxt_s;
  logic [7:0] dst_r, dst_nxt_s;
  logic [7:0] len_r, len_nxt_s;
  logic [7:0] idx_r, idx_nxt_s;
  logic [7:0] hold_r, hold_nxt_s;
  logic       err_r, err_nxt_s;
  logic       src_bad_s, dst_bad_s, range_bad_s;
  logic [7:0] addr_s, data_s;
  logic       mw_s;

  lab3_range_check #(.HOLE(HOLE_ADDR)) u_src_chk (
    .base        (SRC),
    .len         (LEN),
    .covers_hole (src_bad_s)
  );

  lab3_range_check #(.HOLE(HOLE_ADDR)) u_dst_chk (
    .base        (DST),
    .len         (LEN),
    .covers_hole (dst_bad_s)
  );

  assign range_bad_s = src_bad_s | dst_bad_s;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= IDLE;
      src_r   <= 8'd0;
      dst_r   <= 8'd0;
      len_r   <= 8'd0;
      idx_r   <= 8'd0;
      hold_r  <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      src_r   <= src_nxt_s;
      dst_r   <= dst_nxt_s;
      len_r   <= len_nxt_s;
      idx_r   <= idx_nxt_s;
      hold_r  <= hold_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Next-state and bus drive; every bus access waits on GNT in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    src_nxt_s   = src_r;
    dst_nxt_s   = dst_r;
    len_nxt_s   = len_r;
    idx_nxt_s   = idx_r;
    hold_nxt_s  = hold_r;
    err_nxt_s   = err_r;
    addr_s      = 8'd0;
    data_s      = 8'd0;
    mw_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (START) begin
          src_nxt_s = SRC;
          dst_nxt_s = DST;
          len_nxt_s = LEN;
          idx_nxt_s = 8'd0;
          err_nxt_s = range_bad_s;
          if (range_bad_s) begin
            state_nxt_s = FIN;
          end else if (LEN == 8'd0) begin
            state_nxt_s = FIN;
          end else begin
            state_nxt_s = RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        addr_s = wrap_add(src_r, idx_r);
        if (bus.GNT) begin
          hold_nxt_s  = bus.Q;
          state_nxt_s = WR;
        end else begin
          state_nxt_s = RD;
        end
      end
      WR: begin
        addr_s = wrap_add(dst_r, idx_r);
        data_s = hold_r;
        mw_s   = bus.GNT;
        if (bus.GNT) begin
          idx_nxt_s = idx_r + 8'd1;
          if ((idx_r + 8'd1) == len_r) begin
            state_nxt_s = FIN;
          end else begin
            state_nxt_s = RD;
          end
        end else begin
          state_nxt_s = WR;
        end
      end
      FIN: begin
        state_nxt_s = IDLE;
        err_nxt_s   = err_r & HOLD_ERR;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign BUSY     = (state_r == RD) | (state_r == WR);
  assign DONE     = (state_r == FIN);
  assign ERR      = err_r;
  assign bus.REQ  = BUSY;
  assign bus.ADDR = addr_s;
  assign bus.DATA = data_s;
  assign bus.MW   = mw_s;

endmodule

// File: tb/tb_lab3_block_copier.sv
// Randomized bench for lab3_block_copier: a flat 256-byte memory answers the
// bus, and a byte-level copy model predicts memory, ERR and DONE timing.
module tb_lab3_block_copier;
  import lab3_bus_pkg::*;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic [7:0] SRC   = 8'd0;
  logic [7:0] DST   = 8'd0;
  logic [7:0] LEN   = 8'd0;
  logic       BUSY, DONE, ERR;

  lab3_block_copier_if bus ();

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  bit         gnt_pat [4096];
  int         n_tests = 0;
  int         n_fail  = 0;

  assign bus.Q = mem[bus.ADDR];

  always #5 CLK = ~CLK;

  lab3_block_copier dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .SRC   (SRC),
    .DST   (DST),
    .LEN   (LEN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR),
    .bus   (bus)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // True when some byte of [base, base+len) lands on the hole.
  function automatic bit covers(input logic [7:0] base, input logic [7:0] l);
    covers = 1'b0;
    for (int k = 0; k < int'(l); k++)
      if (((int'(base) + k) % 256) == int'(HOLE_ADDR)) covers = 1'b1;
  endfunction

  // One clock: the memory commits a write that was enabled at the edge.
  task automatic tick();
    logic [7:0] wa, wd;
    logic       wm;
    wa = bus.ADDR; wd = bus.DATA; wm = bus.MW;
    @(posedge CLK);
    if (wm === 1'b1) mem[wa] = wd;
    #1;
  endtask

  // mode 0: grant always; 1: random grant plus junk START while busy; 2: grant low in cycles 2..4
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l, input int mode);
    bit bad;
    int done_exp, p, c, nwr, bad_addr, viol, busy_n, req_bad, diffs;
    bit done_seen;
    bad = covers(s, l) || covers(d, l);
    for (int k = 0; k < 4096; k++) begin
      case (mode)
        1:       gnt_pat[k] = ($urandom_range(0, 9) < 7);
        2:       gnt_pat[k] = !(k >= 2 && k <= 4);
        default: gnt_pat[k] = 1'b1;
      endcase
    end
    // Each byte needs one granted read cycle and one granted write cycle.
    done_exp = 0;
    if (bad || l == 8'd0) done_exp = 1;
    else begin
      p = 0;
      for (int cc = 1; cc < 4096 && done_exp == 0; cc++) begin
        if (gnt_pat[cc]) p++;
        if (p == 2 * int'(l)) done_exp = cc + 1;
      end
    end
    for (int k = 0; k < 256; k++) ref_mem[k] = mem[k];
    if (!bad)
      for (int k = 0; k < int'(l); k++)
        ref_mem[(int'(d) + k) % 256] = ref_mem[(int'(s) + k) % 256];

    START = 1'b1; SRC = s; DST = d; LEN = l; bus.GNT = gnt_pat[0];
    tick();
    START = 1'b0;
    c = 1; done_seen = 1'b0; nwr = 0; bad_addr = 0; viol = 0; busy_n = 0; req_bad = 0;
    while (!done_seen && c <= 4000) begin
      bus.GNT = gnt_pat[c];
      if (mode == 1 && c < done_exp) begin
        START = 1'($urandom_range(0, 1));
        SRC = 8'($urandom); DST = 8'($urandom); LEN = 8'($urandom);
      end else begin
        START = 1'b0;
      end
      #1;
      if (bus.MW === 1'b1 && bus.GNT !== 1'b1) viol++;
      if (bus.REQ !== BUSY) req_bad++;
      if (BUSY === 1'b1) busy_n++;
      if (bus.MW === 1'b1) begin
        if (bus.ADDR !== 8'(int'(d) + nwr)) bad_addr++;
        nwr++;
      end
      if (DONE === 1'b1) begin
        done_seen = 1'b1;
        chk_eq("done_cycle", c, done_exp);
        chk_eq("err_at_done", {31'd0, ERR}, {31'd0, bad});
      end
      tick();
      c++;
    end
    START = 1'b0;
    if (!done_seen) chk_eq("done_timeout", 32'd0, 32'd1);
    chk_eq("idle_bus", {DONE, bus.MW, bus.ADDR, bus.DATA}, 18'd0);
    chk_eq("err_sticky", {31'd0, ERR}, {31'd0, bad});
    chk_eq("mw_wo_gnt", viol, 0);
    chk_eq("req_busy", req_bad, 0);
    chk_eq("busy_cycles", busy_n, (bad || l == 8'd0) ? 0 : done_exp - 1);
    chk_eq("write_count", nwr, bad ? 0 : int'(l));
    chk_eq("write_addr", bad_addr, 0);
    diffs = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) diffs++;
    chk_eq("mem_image", diffs, 0);
  endtask

  initial begin
    logic [7:0] pre [4];
    int         busy_after;
    bus.GNT = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk_eq("reset_state", {BUSY, bus.REQ, DONE, ERR, bus.MW, bus.ADDR, bus.DATA}, 21'd0);
    RESET = 1'b1;
    tick();

    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h08; mem[3] = 8'h00;
    run_copy(8'd0, 8'd100, 8'd4, 0);
    run_copy(8'd10, 8'd20, 8'd0, 0);
    run_copy(8'd246, 8'd0, 8'd4, 0);
    run_copy(8'd0, 8'd30, 8'd3, 0);

    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    run_copy(8'd0, IOD, 8'd4, 0);
    chk_eq("iod", mem[IOD], 8'h11);
    chk_eq("ioe", mem[IOE], 8'h22);
    chk_eq("iof", mem[IOF], 8'h33);
    chk_eq("iog", mem[IOG], 8'h44);

    run_copy(8'd40, 8'd60, 8'd2, 2);
    run_copy(8'd250, 8'd10, 8'd3, 0);
    run_copy(8'd249, 8'd5, 8'd255, 0);

    // Reset during the second byte's read of a 4-byte copy.
    for (int k = 0; k < 4; k++) pre[k] = mem[100 + k];
    bus.GNT = 1'b1;
    START = 1'b1; SRC = 8'd0; DST = 8'd100; LEN = 8'd4;
    tick();
    START = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    #1;
    chk_eq("reset_async", {BUSY, bus.REQ, DONE, ERR, bus.MW, bus.ADDR, bus.DATA}, 21'd0);
    tick();
    RESET = 1'b1;
    busy_after = 0;
    for (int k = 0; k < 6; k++) begin
      if (BUSY !== 1'b0) busy_after++;
      tick();
    end
    chk_eq("busy_after_rst", busy_after, 0);
    chk_eq("rst_byte0", mem[100], mem[0]);
    chk_eq("rst_byte1", mem[101], pre[1]);
    chk_eq("rst_byte2", mem[102], pre[2]);
    chk_eq("rst_byte3", mem[103], pre[3]);

    for (int it = 0; it < 40; it++) begin
      logic [7:0] rs, rd, rl;
      rs = 8'($urandom);
      rd = 8'($urandom);
      rl = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      run_copy(rs, rd, rl, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
